led_blink_indicator: RTL and testbench
======================================

# led_blink_indicator

Converts single-cycle event pulses, such as the debounced button-press pulse, into human-visible LED blinks.
- Each accepted event produces one blink: a fixed on-time followed by a fixed dark gap, so consecutive events stay distinguishable by eye.
- Sits between event sources in sysclk logic and a board LED pin; it is the output-side counterpart of button input conditioning.

## Interface
- ON_CYCLES, 12_500_000, LED on-time per blink in sysclk cycles (100 ms at 125 MHz); must be ≥1.
- OFF_CYCLES, 12_500_000, dark gap after each blink in sysclk cycles; must be ≥1.
- MAX_PENDING, 15, saturation limit of the queued-event counter; must be ≥1.
- sysclk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- evt_pulse  input  1  event strobe, already synchronous to sysclk; each high cycle is one event.
- led  output  1  LED drive, registered.
- busy  output  1  high while a blink or its gap is in progress.
- pending  output  $clog2(MAX_PENDING+1)  events queued and not yet blinked.
- dropped  output  1  one-cycle pulse marking a lost event.

## Operation
- Reset values: led=0, busy=0, pending=0, dropped=0, state IDLE, timer 0.
- State machine:
  - IDLE: evt_pulse → ON with timer cleared; the event blinks directly and is never queued.
  - ON: led=1; at timer==ON_CYCLES-1 → OFF with timer cleared.
  - OFF: led=0; at timer==OFF_CYCLES-1, pending>0 → ON and pending decrements; pending==0 → IDLE.
- busy = (state != IDLE), registered alongside state.
- Events arriving in ON or OFF are queued or dropped as set under Configuration.
- Queue and terminal-count boundary cases:
  - An event in the OFF terminal cycle with pending>0: the decrement and the increment cancel, so pending is unchanged.
  - An event in the OFF terminal cycle with pending==0: it is queued (pending→1) and the block goes to IDLE. On the next cycle the block leaves IDLE → ON and pending returns to 0, so that blink starts one cycle after the gap ends.
  - An increment at pending==MAX_PENDING saturates: pending holds and dropped pulses.
- The timer is sized $clog2(max(ON_CYCLES,OFF_CYCLES)) bits, minimum 1. It only counts up and is cleared on every state change, so it never wraps.
- evt_pulse sampled in the same cycle as reset is discarded.

## Timing
- Event high in cycle k (block IDLE): led and busy are high from cycle k+1 for exactly ON_CYCLES cycles. led is then low for OFF_CYCLES cycles while busy stays high.
- Queued blinks run back-to-back: exactly OFF_CYCLES dark cycles between blinks, and no IDLE cycle between them.
- dropped goes high in cycle k+1 for a loss in cycle k, for exactly one cycle per lost event.
- Reset asserted in cycle r: all outputs are at their reset values from cycle r+1, whatever state the block was in.

## Configuration
- LED_BLINK_PENDING_EN defined:
  - Events arriving while busy increment pending, saturating at MAX_PENDING.
  - Every queued event blinks in order.
- LED_BLINK_PENDING_EN undefined:
  - Events arriving while busy are discarded and each one pulses dropped.
  - The pending port is tied to 0 and the queue counter is not built.
  - OFF terminal always → IDLE.

## Structure
- Package led_blink_pkg holds:
  - the state enum typedef (IDLE, ON, OFF);
  - a function returning the timer width from ON_CYCLES and OFF_CYCLES.
- One sub-module, cycle_timer:
  - clear-and-count up-counter with a width parameter and a terminal-count input;
  - outputs a terminal-count hit flag.

## Test plan
All scenarios use ON_CYCLES=4, OFF_CYCLES=3, MAX_PENDING=2.
- Single event at cycle 10 → led=1 in cycles 11–14, led=0 in 15–17, busy=1 in 11–17, busy=0 at 18.
- (PENDING_EN) Events at 10, 12, 13 → pending=1 at 13 and 2 at 14; blink starts at 11, 18, 25; pending=0 from 18+7=25; busy falls at 32.
- (PENDING_EN) Events at 10, 12, 13, 14 → pending holds at 2; dropped=1 only at cycle 15; exactly three blinks.
- (PENDING_EN) Pending=1 and an event in the OFF terminal cycle 17 → pending stays 1 at 18; the next blink starts at 18.
- (no PENDING_EN) Events at 10 and 12 → one blink (11–14); dropped=1 at 13; pending=0 throughout.
- Reset at cycle 13 mid-blink with pending=1 → at 14 led=0, busy=0, pending=0. A new event at 20 → led=1 in cycles 21–24.

Source files
------------

// File: rtl/led_blink_pkg.sv
// Shared types and helpers for the LED blink indicator.
package led_blink_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;

  // The timer counts 0..max(ON,OFF)-1, so this many bits hold it without wrap.
  function automatic int timer_width(input int on_c, input int off_c);
    int m;
    int w;
    m = (on_c > off_c) ? on_c : off_c;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/led_blink_indicator_cycle_timer.sv
// Clear-and-count up-counter with a terminal-count compare.
module cycle_timer #(
  parameter int W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic [W-1:0] i_tc,
  output logic         o_hit
);

  logic [W-1:0] r_cnt;

  // Count up every cycle unless cleared; the owner clears on each phase change.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) r_cnt <= '0;
    else                r_cnt <= r_cnt + 1'b1;
  end

  assign o_hit = (r_cnt == i_tc);

endmodule

// File: rtl/led_blink_indicator.sv
// Turns single-cycle event pulses into visible LED blinks (on-time + dark gap).
// Optional feature macro: LED_BLINK_PENDING_EN -- when defined, events that
// arrive mid-blink are counted and blinked later; otherwise they are dropped.
module led_blink_indicator
  import led_blink_pkg::*;
#(
  parameter  int ON_CYCLES   = 12_500_000,
  parameter  int OFF_CYCLES  = 12_500_000,
  parameter  int MAX_PENDING = 15,
  localparam int PW          = $clog2(MAX_PENDING + 1)
) (
  input  logic          sysclk,
  input  logic          reset,
  input  logic          evt_pulse,
  output logic          led,
  output logic          busy,
  output logic [PW-1:0] pending,
  output logic          dropped
);

  localparam int          TW     = timer_width(ON_CYCLES, OFF_CYCLES);
  localparam logic [TW-1:0] ON_TC  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_TC = TW'(OFF_CYCLES - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_led;
  logic            r_busy;
  logic            r_dropped;
  logic [TW-1:0]   w_tc;
  logic            w_hit;
  logic            w_clr;
  logic            w_pend_nz;
  logic            w_drop;

  // Terminal count follows the current phase; IDLE holds the timer at zero.
  assign w_tc  = (r_state == OFF) ? OFF_TC : ON_TC;
  assign w_clr = (w_state_nxt != r_state) || (r_state == IDLE);

  cycle_timer #(.W(TW)) u_timer (
    .i_clk (sysclk),
    .i_rst (reset),
    .i_clr (w_clr),
    .i_tc  (w_tc),
    .o_hit (w_hit)
  );

`ifdef LED_BLINK_PENDING_EN
  logic [PW-1:0] r_pending;
  logic          w_inc;
  logic          w_dec;
  logic          w_sat;

  // An event in IDLE with nothing queued blinks directly; every other event
  // queues. Leaving IDLE or finishing a gap with work queued consumes one.
  assign w_pend_nz = (r_pending != '0);
  assign w_inc     = evt_pulse && !((r_state == IDLE) && !w_pend_nz);
  assign w_dec     = w_pend_nz && ((r_state == IDLE) || ((r_state == OFF) && w_hit));
  assign w_sat     = (r_pending == PW'(MAX_PENDING));
  assign w_drop    = w_inc && !w_dec && w_sat;

  // Queue counter; a simultaneous increment and decrement cancel out.
  always_ff @(posedge sysclk) begin
    if (reset)                          r_pending <= '0;
    else if (w_inc && !w_dec && !w_sat) r_pending <= r_pending + 1'b1;
    else if (w_dec && !w_inc)           r_pending <= r_pending - 1'b1;
  end

  assign pending = r_pending;
`else
  assign w_pend_nz = 1'b0;
  assign w_drop    = evt_pulse && (r_state != IDLE);
  assign pending   = '0;
`endif

  // Next-state: blink on event (or leftover queued event), gap, then repeat or rest.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (evt_pulse || w_pend_nz) w_state_nxt = ON;
      ON:      if (w_hit)                  w_state_nxt = OFF;
      OFF:     if (w_hit)                  w_state_nxt = w_pend_nz ? ON : IDLE;
      default:                             w_state_nxt = IDLE;
    endcase
  end

  // State and registered outputs update together so led/busy track the state.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_led     <= 1'b0;
      r_busy    <= 1'b0;
      r_dropped <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_led     <= (w_state_nxt == ON);
      r_busy    <= (w_state_nxt != IDLE);
      r_dropped <= w_drop;
    end
  end

  assign led     = r_led;
  assign busy    = r_busy;
  assign dropped = r_dropped;

endmodule

// File: tb/tb_led_blink_indicator.sv
// Scoreboard bench for led_blink_indicator (ON=4, OFF=3, MAX_PENDING=2).
module tb_led_blink_indicator;

  localparam int ON   = 4;
  localparam int OFF  = 3;
  localparam int MAXP = 2;
  localparam int PW   = $clog2(MAXP + 1);
  localparam int SCN_LEN = 36;

  logic          sysclk = 1'b0;
  logic          reset  = 1'b1;
  logic          evt_pulse = 1'b0;
  logic          led;
  logic          busy;
  logic [PW-1:0] pending;
  logic          dropped;

  led_blink_indicator #(
    .ON_CYCLES   (ON),
    .OFF_CYCLES  (OFF),
    .MAX_PENDING (MAXP)
  ) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .evt_pulse (evt_pulse),
    .led       (led),
    .busy      (busy),
    .pending   (pending),
    .dropped   (dropped)
  );

  always #5 sysclk = ~sysclk;

  int cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  typedef struct {
    int    cyc;
    int    rel;
    logic  led;
    logic  busy;
    int    pend;
    logic  drop;
    string nm;
  } exp_t;

  typedef int a4_t[4];
  typedef int a3_t[3];
  typedef int a2_t[2];

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Monitor: outputs are presented every cycle; pop the entry due now and compare.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge sysclk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        checks++;
        if (e.cyc != cyc) begin
          errors++;
          $display("FAIL %s rel %0d: entry checked at cycle %0d, required cycle %0d",
                   e.nm, e.rel, cyc, e.cyc);
        end else if (led !== e.led || busy !== e.busy || int'(pending) != e.pend ||
                     dropped !== e.drop) begin
          errors++;
          $display("FAIL %s rel %0d: got led=%0b busy=%0b pending=%0d dropped=%0b, required led=%0b busy=%0b pending=%0d dropped=%0b",
                   e.nm, e.rel, led, busy, pending, dropped, e.led, e.busy, e.pend, e.drop);
        end
      end
    end
  end

  // One scenario: reset, queue the hand-written expected trace, then play events.
  // ev: event cycles; rc: reset cycle (-1 none); ls/le: led-on intervals;
  // bs/be: busy intervals; pc/pv: pending value steps; dr: dropped cycles.
  task automatic run_scn(input string nm, input a4_t ev, input int rc,
                         input a3_t ls, input a3_t le, input a2_t bs, input a2_t be,
                         input a4_t pc, input a4_t pv, input a2_t dr);
    int   base;
    exp_t e;
    reset = 1'b1;
    evt_pulse = 1'b0;
    @(posedge sysclk); #1;
    reset = 1'b0;
    base = cyc;
    for (int k = 0; k < SCN_LEN; k++) begin
      e.cyc  = base + k;
      e.rel  = k;
      e.nm   = nm;
      e.led  = 1'b0;
      e.busy = 1'b0;
      e.pend = 0;
      for (int i = 0; i < 3; i++)
        if (ls[i] >= 0 && k >= ls[i] && k <= le[i]) e.led = 1'b1;
      for (int i = 0; i < 2; i++)
        if (bs[i] >= 0 && k >= bs[i] && k <= be[i]) e.busy = 1'b1;
      for (int i = 0; i < 4; i++)
        if (pc[i] >= 0 && k >= pc[i]) e.pend = pv[i];
      e.drop = (k == dr[0]) || (k == dr[1]);
      q.push_back(e);
    end
    for (int k = 0; k < SCN_LEN; k++) begin
      evt_pulse = (k == ev[0]) || (k == ev[1]) || (k == ev[2]) || (k == ev[3]);
      reset     = (k == rc);
      @(posedge sysclk); #1;
    end
    evt_pulse = 1'b0;
    reset     = 1'b0;
  endtask

  initial begin : stim
    run_scn("single", '{10, -1, -1, -1}, -1, '{11, -1, -1}, '{14, -1, -1},
            '{11, -1}, '{17, -1}, '{-1, -1, -1, -1}, '{0, 0, 0, 0}, '{-1, -1});
`ifdef LED_BLINK_PENDING_EN
    run_scn("queue3", '{10, 12, 13, -1}, -1, '{11, 18, 25}, '{14, 21, 28},
            '{11, -1}, '{31, -1}, '{13, 14, 18, 25}, '{1, 2, 1, 0}, '{-1, -1});
    run_scn("saturate", '{10, 12, 13, 14}, -1, '{11, 18, 25}, '{14, 21, 28},
            '{11, -1}, '{31, -1}, '{13, 14, 18, 25}, '{1, 2, 1, 0}, '{15, -1});
    run_scn("offterm_pend", '{10, 12, 17, -1}, -1, '{11, 18, 25}, '{14, 21, 28},
            '{11, -1}, '{31, -1}, '{13, 25, -1, -1}, '{1, 0, 0, 0}, '{-1, -1});
    run_scn("offterm_empty", '{10, 17, -1, -1}, -1, '{11, 19, -1}, '{14, 22, -1},
            '{11, 19}, '{17, 25}, '{18, 19, -1, -1}, '{1, 0, 0, 0}, '{-1, -1});
    run_scn("reset_mid", '{10, 12, 13, 20}, 13, '{11, 21, -1}, '{13, 24, -1},
            '{11, 21}, '{13, 27}, '{13, 14, -1, -1}, '{1, 0, 0, 0}, '{-1, -1});
`else
    run_scn("drop", '{10, 12, -1, -1}, -1, '{11, -1, -1}, '{14, -1, -1},
            '{11, -1}, '{17, -1}, '{-1, -1, -1, -1}, '{0, 0, 0, 0}, '{13, -1});
    run_scn("offterm_drop", '{10, 17, -1, -1}, -1, '{11, -1, -1}, '{14, -1, -1},
            '{11, -1}, '{17, -1}, '{-1, -1, -1, -1}, '{0, 0, 0, 0}, '{18, -1});
    run_scn("reset_mid", '{10, 12, 13, 20}, 13, '{11, 21, -1}, '{13, 24, -1},
            '{11, 21}, '{13, 27}, '{-1, -1, -1, -1}, '{0, 0, 0, 0}, '{13, -1});
`endif
    repeat (2) @(posedge sysclk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left unchecked, required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
